// File: rtl/axis_eth_tx_framer.sv
// rtl/axis_eth_tx_framer.sv - Ethernet TX framer: preamble/SFD, zero pad, CRC-32 FCS
module axis_eth_tx_framer #(
    parameter int MIN_FRAME_BYTES = 60,
    parameter int PREAMBLE_BYTES  = 7
) (
    input  logic       clock,
    input  logic       aresetn,
    input  logic [7:0] saxis_tdata,
    input  logic       saxis_tvalid,
    output logic       saxis_tready,
    input  logic       saxis_tlast,
    output logic [7:0] maxis_tdata,
    output logic       maxis_tvalid,
    input  logic       maxis_tready,
    output logic       maxis_tlast
);

    // Length counter is wide enough to hold MIN_FRAME_BYTES, never narrower than 1 bit.
    localparam int            LW_RAW   = $clog2(MIN_FRAME_BYTES + 1);
    localparam int            LW       = (LW_RAW < 1) ? 1 : LW_RAW;
    localparam logic [LW:0]   MIN_L    = (LW + 1)'(MIN_FRAME_BYTES);
    localparam logic [3:0]    PRE_N    = 4'(PREAMBLE_BYTES);
    localparam logic [31:0]   CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0]   CRC_POLY = 32'hEDB8_8320;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_PAYLOAD,
        S_PAD,
        S_FCS
    } state_t;

    state_t          state_q;
    logic [7:0]      tdata_q;
    logic            tvalid_q;
    logic            tlast_q;
    logic [31:0]     crc_q;
    logic [LW-1:0]   len_q;
    logic [3:0]      cnt_q;

    logic            adv;
    logic [LW:0]     len_p1;
    logic [LW-1:0]   len_d;
    logic [7:0]      upd_byte;
    logic [31:0]     crc_d;
    logic [31:0]     fcs;
    logic [7:0]      fcs_byte;

    // Reflected CRC-32 advanced by one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // Output register advance, upstream ready, and next values for crc/len/FCS byte.
    always_comb begin
        adv          = !tvalid_q || maxis_tready;
        saxis_tready = (state_q == S_PAYLOAD) && adv;
        len_p1       = {1'b0, len_q} + {{LW{1'b0}}, 1'b1};
        len_d        = (len_p1 >= MIN_L) ? MIN_L[LW-1:0] : len_p1[LW-1:0];
        upd_byte     = (state_q == S_PAD) ? 8'h00 : saxis_tdata;
        crc_d        = crc_byte(crc_q, upd_byte);
        fcs          = ~crc_q;
        case (cnt_q[1:0])
            2'd0:    fcs_byte = fcs[7:0];
            2'd1:    fcs_byte = fcs[15:8];
            2'd2:    fcs_byte = fcs[23:16];
            default: fcs_byte = fcs[31:24];
        endcase
    end

    assign maxis_tdata  = tdata_q;
    assign maxis_tvalid = tvalid_q;
    assign maxis_tlast  = tlast_q;

    // Framing FSM with the output register; everything moves only when the register can advance.
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            tdata_q  <= 8'h00;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            crc_q    <= CRC_INIT;
            len_q    <= '0;
            cnt_q    <= 4'd0;
        end else begin
            // Idle holds the per-frame accumulators at their start values.
            if (state_q == S_IDLE) begin
                crc_q <= CRC_INIT;
                len_q <= '0;
            end
            if (adv) begin
                // Nothing loaded this cycle means the register empties.
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                case (state_q)
                    S_IDLE: begin
                        if (saxis_tvalid) begin
                            tdata_q  <= 8'h55;
                            tvalid_q <= 1'b1;
                            cnt_q    <= 4'd1;
                            state_q  <= S_PREAMBLE;
                        end
                    end
                    S_PREAMBLE: begin
                        tvalid_q <= 1'b1;
                        if (cnt_q == PRE_N) begin
                            tdata_q <= 8'hD5;
                            cnt_q   <= 4'd0;
                            state_q <= S_PAYLOAD;
                        end else begin
                            tdata_q <= 8'h55;
                            cnt_q   <= cnt_q + 4'd1;
                        end
                    end
                    S_PAYLOAD: begin
                        if (saxis_tvalid) begin
                            tdata_q  <= saxis_tdata;
                            tvalid_q <= 1'b1;
                            crc_q    <= crc_d;
                            len_q    <= len_d;
                            if (saxis_tlast) begin
                                cnt_q   <= 4'd0;
                                state_q <= (len_p1 < MIN_L) ? S_PAD : S_FCS;
                            end
                        end
                    end
                    S_PAD: begin
                        tdata_q  <= 8'h00;
                        tvalid_q <= 1'b1;
                        crc_q    <= crc_d;
                        len_q    <= len_d;
                        if (len_p1 == MIN_L) begin
                            cnt_q   <= 4'd0;
                            state_q <= S_FCS;
                        end
                    end
                    S_FCS: begin
                        tdata_q  <= fcs_byte;
                        tvalid_q <= 1'b1;
                        cnt_q    <= cnt_q + 4'd1;
                        if (cnt_q == 4'd3) begin
                            tlast_q <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_eth_tx_framer.sv
// tb/tb_axis_eth_tx_framer.sv - self-checking bench for axis_eth_tx_framer
module tb_axis_eth_tx_framer;

    logic       clock = 1'b0;
    logic       aresetn;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       m_tready;
    logic       sel;

    logic [7:0] d0_tdata, d1_tdata;
    logic       d0_tvalid, d1_tvalid, d0_tlast, d1_tlast, d0_sready, d1_sready;
    logic [7:0] mon_tdata;
    logic       mon_tvalid, mon_tlast, s_tready;

    always #5 clock = ~clock;

    // dut0 covers the unpadded configuration, dut the defaults; sel routes traffic.
    axis_eth_tx_framer #(.MIN_FRAME_BYTES(0), .PREAMBLE_BYTES(7)) dut0 (
        .clock(clock), .aresetn(aresetn),
        .saxis_tdata(s_tdata), .saxis_tvalid(s_tvalid && sel), .saxis_tready(d0_sready), .saxis_tlast(s_tlast),
        .maxis_tdata(d0_tdata), .maxis_tvalid(d0_tvalid), .maxis_tready(m_tready), .maxis_tlast(d0_tlast)
    );
    axis_eth_tx_framer dut (
        .clock(clock), .aresetn(aresetn),
        .saxis_tdata(s_tdata), .saxis_tvalid(s_tvalid && !sel), .saxis_tready(d1_sready), .saxis_tlast(s_tlast),
        .maxis_tdata(d1_tdata), .maxis_tvalid(d1_tvalid), .maxis_tready(m_tready), .maxis_tlast(d1_tlast)
    );

    assign mon_tdata  = sel ? d0_tdata  : d1_tdata;
    assign mon_tvalid = sel ? d0_tvalid : d1_tvalid;
    assign mon_tlast  = sel ? d0_tlast  : d1_tlast;
    assign s_tready   = sel ? d0_sready : d1_sready;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    // Reference model: expected beat stream and payload lengths of pending frames.
    logic [7:0] exp_data[$];
    logic       exp_last[$];
    int         plen[$];
    logic [7:0] pay[0:255];

    task automatic push_frame(input int n, input int minb);
        logic [31:0] c;
        logic [31:0] f;
        int          body;
        c    = 32'hFFFFFFFF;
        body = (n > minb) ? n : minb;
        for (int i = 0; i < 7; i++) begin exp_data.push_back(8'h55); exp_last.push_back(1'b0); end
        exp_data.push_back(8'hD5); exp_last.push_back(1'b0);
        for (int i = 0; i < body; i++) begin
            logic [7:0] b;
            b = (i < n) ? pay[i] : 8'h00;
            c = crc_upd(c, b);
            exp_data.push_back(b); exp_last.push_back(1'b0);
        end
        f = ~c;
        for (int k = 0; k < 4; k++) begin
            exp_data.push_back(f[8*k +: 8]);
            exp_last.push_back(k == 3);
        end
        plen.push_back(n);
    endtask

    // Monitor state and captured frames.
    int         cyc = 0;
    int         hs = 0;
    int         first_cyc = 0, prev_end_cyc = 0;
    logic [7:0] cap[0:255];
    logic [7:0] last_frame[0:255];
    int         last_len = 0, last_span = 0, last_gap = 0, frames = 0;
    logic       pv_valid = 1'b0, pv_ready = 1'b0, pv_last = 1'b0;
    logic [7:0] pv_data = 8'h00;

    // Compare process: every negedge, check outputs against the model.
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (!aresetn) begin
                exp_data.delete(); exp_last.delete(); plen.delete();
                hs = 0; pv_valid = 1'b0; pv_ready = 1'b0;
            end else begin
                int  l;
                logic exp_tr;
                if (pv_valid && !pv_ready) begin
                    chk("stall_valid", {31'd0, mon_tvalid}, 32'd1);
                    chk("stall_data", {24'd0, mon_tdata}, {24'd0, pv_data});
                    chk("stall_last", {31'd0, mon_tlast}, {31'd0, pv_last});
                end
                l = hs + (mon_tvalid ? 1 : 0);
                exp_tr = (!mon_tvalid || m_tready) && (plen.size() > 0) && (l >= 8) && (l < 8 + plen[0]);
                chk("saxis_tready", {31'd0, s_tready}, {31'd0, exp_tr});
                if (mon_tvalid && m_tready) begin
                    if (exp_data.size() == 0) begin
                        chk("unexpected_beat", {24'd0, mon_tdata}, 32'hFFFF_FFFF);
                    end else begin
                        logic [7:0] ed;
                        logic       el;
                        ed = exp_data.pop_front();
                        el = exp_last.pop_front();
                        chk("beat_data", {24'd0, mon_tdata}, {24'd0, ed});
                        chk("beat_last", {31'd0, mon_tlast}, {31'd0, el});
                        if (hs == 0) first_cyc = cyc;
                        cap[hs] = mon_tdata;
                        hs++;
                        if (el) begin
                            last_frame   = cap;
                            last_len     = hs;
                            last_span    = cyc - first_cyc + 1;
                            last_gap     = first_cyc - prev_end_cyc;
                            prev_end_cyc = cyc;
                            frames++;
                            hs = 0;
                            void'(plen.pop_front());
                        end
                    end
                end
                pv_valid = mon_tvalid; pv_ready = m_tready;
                pv_data  = mon_tdata;  pv_last  = mon_tlast;
            end
        end
    end

    // Downstream ready: always on, or a coin flip each cycle.
    logic rnd_ready = 1'b0;
    logic rnd_valid = 1'b0;
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clock); #1;
            m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    int   drv_idx = 0;
    logic abort = 1'b0;

    task automatic send(input int n);
        int idx;
        int guard;
        idx = 0; guard = 0; drv_idx = 0;
        while (idx < n && !abort && guard < 4000) begin
            @(posedge clock); #1;
            if (rnd_valid && $urandom_range(0, 2) == 0) begin
                s_tvalid = 1'b0;
            end else begin
                s_tvalid = 1'b1;
                s_tdata  = pay[idx];
                s_tlast  = (idx == n - 1);
            end
            @(negedge clock);
            if (s_tvalid && s_tready) begin idx++; drv_idx = idx; end
            guard++;
        end
        if (!abort) chk("send_done", idx, n);
        @(posedge clock); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (exp_data.size() == 0) break;
            @(negedge clock);
        end
        chk("drain_timeout", exp_data.size(), 0);
        repeat (2) @(negedge clock);
    endtask

    logic [7:0] frame2[0:255];
    logic [31:0] r;
    int diffs;
    int f0;

    initial begin
        aresetn = 1'b0; sel = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_tvalid", {31'd0, mon_tvalid}, 32'd0);
        chk("rst_tdata", {24'd0, mon_tdata}, 32'd0);
        chk("rst_tlast", {31'd0, mon_tlast}, 32'd0);
        chk("rst_sready", {31'd0, s_tready}, 32'd0);
        #2 aresetn = 1'b1;
        repeat (2) @(posedge clock);

        // Unpadded known-answer frame "123456789".
        sel = 1'b1;
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        push_frame(9, 0);
        send(9);
        wait_idle();
        chk("t1_len", last_len, 21);
        chk("t1_span", last_span, 21);
        chk("t1_sfd", {24'd0, last_frame[7]}, 32'hD5);
        chk("t1_fcs0", {24'd0, last_frame[17]}, 32'h26);
        chk("t1_fcs1", {24'd0, last_frame[18]}, 32'h39);
        chk("t1_fcs2", {24'd0, last_frame[19]}, 32'hF4);
        chk("t1_fcs3", {24'd0, last_frame[20]}, 32'hCB);
        sel = 1'b0;
        repeat (2) @(posedge clock);

        // Short frame padded to 60 bytes.
        for (int i = 0; i < 14; i++) pay[i] = 8'(i + 1);
        push_frame(14, 60);
        send(14);
        wait_idle();
        chk("t2_len", last_len, 72);
        chk("t2_pad", {24'd0, last_frame[67]}, 32'h00);
        r = 32'hFFFFFFFF;
        for (int i = 8; i < 72; i++) r = crc_upd(r, last_frame[i]);
        chk("t2_residue", r, 32'hDEBB20E3);
        frame2 = last_frame;

        // Long frame, no pad, no bubbles.
        for (int i = 0; i < 100; i++) pay[i] = 8'((i * 7 + 3) & 8'hFF);
        push_frame(100, 60);
        send(100);
        wait_idle();
        chk("t3_len", last_len, 112);
        chk("t3_span", last_span, 112);

        // Short frame again under random back-pressure and upstream gaps.
        for (int i = 0; i < 14; i++) pay[i] = 8'(i + 1);
        rnd_ready = 1'b1; rnd_valid = 1'b1;
        push_frame(14, 60);
        send(14);
        wait_idle();
        rnd_ready = 1'b0; rnd_valid = 1'b0;
        diffs = 0;
        for (int i = 0; i < 72; i++) if (last_frame[i] !== frame2[i]) diffs++;
        chk("t4_len", last_len, 72);
        chk("t4_same", diffs, 0);
        repeat (2) @(posedge clock);

        // Back-to-back frames.
        f0 = frames;
        for (int i = 0; i < 20; i++) pay[i] = 8'hA0 + 8'(i);
        push_frame(20, 60);
        send(20);
        for (int i = 0; i < 65; i++) pay[i] = 8'(255 - i);
        push_frame(65, 60);
        send(65);
        wait_idle();
        chk("t5_frames", frames - f0, 2);
        chk("t5_gap", last_gap, 1);
        chk("t5_len", last_len, 77);

        // Reset in mid-payload, then a clean frame.
        for (int i = 0; i < 40; i++) pay[i] = 8'h10 + 8'(i);
        push_frame(40, 60);
        fork
            send(40);
        join_none
        for (int i = 0; i < 500; i++) begin
            if (drv_idx >= 20) break;
            @(negedge clock);
        end
        chk("t6_reach20", (drv_idx >= 20) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clock); #3;
        aresetn = 1'b0; abort = 1'b1;
        #1;
        chk("t6_tvalid", {31'd0, mon_tvalid}, 32'd0);
        chk("t6_tdata", {24'd0, mon_tdata}, 32'd0);
        chk("t6_tlast", {31'd0, mon_tlast}, 32'd0);
        chk("t6_sready", {31'd0, s_tready}, 32'd0);
        repeat (3) @(posedge clock);
        #1 aresetn = 1'b1;
        abort = 1'b0;
        repeat (2) @(posedge clock);
        for (int i = 0; i < 30; i++) pay[i] = 8'h80 ^ 8'(i);
        push_frame(30, 60);
        send(30);
        wait_idle();
        chk("t6_len", last_len, 72);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
